// File: rtl/median_pkg.sv
// Shared types and constants for the median sorter and its streaming front-end.
package median_pkg;

    typedef logic [31:0] data_t;

    localparam int MEDIAN_N = 10;
    localparam int SEQ_W    = 16;

    // FILL: window not yet complete for the current stream; RUN: window full.
    typedef enum logic {
        ST_FILL,
        ST_RUN
    } state_t;

endpackage

// File: rtl/median_window_10.sv
// Sliding 10-sample window feeding the median sorter; emits every STRIDE samples
// once full and holds the presented window stable under backpressure.
module median_window_10
    import median_pkg::*;
#(
    parameter int N      = MEDIAN_N,
    parameter int STRIDE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  data_t            in_data,
    input  logic             in_last,
    output logic             win_valid,
    input  logic             win_ready,
    output data_t            win_0,
    output data_t            win_1,
    output data_t            win_2,
    output data_t            win_3,
    output data_t            win_4,
    output data_t            win_5,
    output data_t            win_6,
    output data_t            win_7,
    output data_t            win_8,
    output data_t            win_9,
    output logic [SEQ_W-1:0] win_seq,
    output logic             partial_drop
);

    localparam logic [3:0] FILL_FULL = 4'(N);
    localparam logic [3:0] STRIDE_W  = 4'(STRIDE);

    state_t           state_reg, state_next;
    logic [3:0]       fill_reg, fill_next, fill_post;
    logic [3:0]       since_reg, since_next;
    logic             win_valid_reg, win_valid_next;
    logic             drop_reg, drop_next;
    logic [SEQ_W-1:0] seq_reg, seq_next;
    data_t            win_reg   [0:N-1];
    data_t            win_shift [0:N-1];

    logic accept;
    logic consume;
    logic full;
    logic emit;

    // A held window blocks intake so the lanes cannot shift under the sorter.
    assign in_ready = !rst && !(win_valid_reg && !win_ready);
    assign accept   = in_valid && in_ready;
    assign consume  = win_valid_reg && win_ready;
    assign full     = (state_reg == ST_RUN);

    generate
        for (genvar gi = 0; gi < N - 1; gi++) begin : g_shift
            assign win_shift[gi] = win_reg[gi+1];
        end
    endgenerate
    assign win_shift[N-1] = in_data;

    always_comb begin
        fill_post      = full ? FILL_FULL : fill_reg + 4'd1;
        emit           = accept && (fill_post == FILL_FULL) &&
                         ((fill_reg == FILL_FULL - 4'd1) || (since_reg + 4'd1 == STRIDE_W));
        fill_next      = fill_reg;
        since_next     = since_reg;
        state_next     = state_reg;
        drop_next      = 1'b0;
        if (accept) begin
            if (in_last) begin
                // Stream boundary: the emit decision above still applies to this sample.
                fill_next  = 4'd0;
                since_next = 4'd0;
                state_next = ST_FILL;
                drop_next  = (fill_post != FILL_FULL);
            end else begin
                fill_next  = fill_post;
                state_next = (fill_post == FILL_FULL) ? ST_RUN : ST_FILL;
                if (emit) begin
                    since_next = 4'd0;
                end else if (fill_post == FILL_FULL) begin
                    since_next = since_reg + 4'd1;
                end
            end
        end
        win_valid_next = emit ? 1'b1 : (consume ? 1'b0 : win_valid_reg);
        seq_next       = consume ? seq_reg + 1'b1 : seq_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_FILL;
            fill_reg      <= 4'd0;
            since_reg     <= 4'd0;
            win_valid_reg <= 1'b0;
            drop_reg      <= 1'b0;
            seq_reg       <= '0;
            for (int i = 0; i < N; i++) begin
                win_reg[i] <= '0;
            end
        end else begin
            state_reg     <= state_next;
            fill_reg      <= fill_next;
            since_reg     <= since_next;
            win_valid_reg <= win_valid_next;
            drop_reg      <= drop_next;
            seq_reg       <= seq_next;
            if (accept) begin
                for (int i = 0; i < N; i++) begin
                    win_reg[i] <= win_shift[i];
                end
            end
        end
    end

    assign win_valid    = win_valid_reg;
    assign win_seq      = seq_reg;
    assign partial_drop = drop_reg;
    assign win_0        = win_reg[0];
    assign win_1        = win_reg[1];
    assign win_2        = win_reg[2];
    assign win_3        = win_reg[3];
    assign win_4        = win_reg[4];
    assign win_5        = win_reg[5];
    assign win_6        = win_reg[6];
    assign win_7        = win_reg[7];
    assign win_8        = win_reg[8];
    assign win_9        = win_reg[9];

endmodule

// File: doc/median_window_10.md
# median_window_10

Streaming front-end for the 10-input median sorting network. Accepts one 32-bit sample per cycle over a valid/ready handshake and keeps a sliding window of the last 10 accepted samples. Each completed window is presented as 10 parallel registered lanes, held stable under backpressure. The lanes connect directly to the sorter's `data_0..data_9` inputs.

## Interface
- `N`, 10: window length; only 10 is supported, elaborated as a constant.
- `STRIDE`, 1: accepted samples between successive windows once the window is full; legal range 1..10.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: block can accept a sample this cycle.
- `in_data` in 32 (`data_t`): sample.
- `in_last` in 1: qualifies `in_data`; marks the final sample of a stream.
- `win_valid` out 1: window lanes are valid.
- `win_ready` in 1: downstream consumes the window.
- `win_0..win_9` out 32 each: window lanes; `win_0` is the oldest sample, `win_9` the newest.
- `win_seq` out 16: sequence number of the presented window; wraps from 0xFFFF to 0.
- `partial_drop` out 1: one-cycle pulse when a stream ends before filling a window.

## Operation
- A sample is accepted when `in_valid && in_ready`.
- On accept: the shift register moves `win_k <= win_{k+1}` and `win_9 <= in_data`. The fill counter `fill` (0..10) saturates at 10.
- Emit rule, evaluated on the accepted sample:
  - The post-accept fill must equal 10.
  - Emit if the pre-accept fill was 9 (first window of the stream).
  - Otherwise emit if `since+1 == STRIDE`, where `since` counts accepted samples since the last emit.
- On emit: set `win_valid` next cycle, reset `since` to 0, increment `win_seq` after the window is consumed.
- When not emitting, `since` increments on each accept while fill is 10.
- `in_ready = !rst && !(win_valid && !win_ready)`.
  - While a window is held, no shift occurs, so the lanes are stable.
  - If the window is consumed and a new sample accepted in the same cycle, the shift happens and `win_valid` next cycle reflects the new emit decision.
- `win_valid` clears on consume unless a new emit happens in the same cycle.
- `win_seq` increments on each consume, i.e. `win_valid && win_ready`.
- `in_last` on an accepted sample:
  - Emit rule is evaluated first.
  - Then `fill` and `since` clear, so the next sample starts a new stream.
  - Old lane contents are kept but never presented as part of a new window until that window has 10 fresh samples.
  - If post-accept fill < 10, pulse `partial_drop` next cycle and emit nothing.
- States:
  - FILL (fill < 10): moves to RUN when fill reaches 10.
  - RUN (fill == 10): moves to FILL on `in_last`.
  - `win_valid` is an orthogonal hold flag, not a state.

## Timing
- Latency: the window appears one cycle after the accept edge of its newest sample. The sorter is combinational, so sorted data is valid in the same cycle as `win_valid`.
- Sustained throughput is one sample per cycle when `win_ready` is held high.
- Reset values: `win_valid` 0, `win_0..9` 0, `win_seq` 0, `partial_drop` 0, fill 0, `since` 0.
- `in_ready` is 0 while `rst` is high and 1 in the first cycle after release.
- Asserting reset mid-hold or mid-fill clears everything asynchronously; any pending window is lost.
- `in_last` on the 10th sample emits the window with no drop pulse.
- `in_valid` without `in_ready` has no effect, and `in_data` may change freely while not accepted.

## Structure
- Shared package `median_pkg`:
  - `typedef logic [31:0] data_t`.
  - `localparam int MEDIAN_N = 10`.
  - `localparam int SEQ_W = 16`.
- No sub-module. The shift register, fill/stride counters and hold flag form one always_ff process plus combinational `in_ready`.
- The parent instantiates this block beside the sorter.

## Test plan
- Reset, then feed samples 1..10 with `win_ready=1` → `win_valid` one cycle after the 10th accept; lanes = 1..10 in order; `win_seq=0`.
- Continue with sample 11 (STRIDE=1) → window 2..11; `win_seq=1`; `in_ready` stays high throughout.
- Hold `win_ready=0` on window 1..10 with sample 11 pending for 5 cycles → `in_ready=0`; lanes unchanged. Release `win_ready` → sample 11 accepted in that cycle; window 2..11 appears next cycle.
- Send `in_last` on the 4th sample of a stream → `partial_drop` pulses once, no window. Then feed 100..109 → window 100..109.
- STRIDE=3, samples 1..16 → exactly three windows: 1..10, 4..13, 7..16; `win_seq` 0, 1, 2.
- Assert `rst` asynchronously mid-cycle during a held window → `win_valid`, lanes and `win_seq` read 0 before the next clock edge; the next 10 samples produce a fresh window with `win_seq=0`.
